// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter
//   Stopwatch timebase plus a 4-digit BCD counter in SS.hh format
//   (00.00 .. 59.99). The counter advances one hundredth of a second per tick.
//   The tick is produced by dividing clk by DIV = CLK_HZ / TICK_HZ.
//   CLK_HZ must be an integer multiple of TICK_HZ, and DIV must be >= 2.
//
// Ports
//   clk        in   system clock, everything on posedge
//   rst        in   synchronous active-high reset
//   btn_start  in   start/stop button level (debounced), acts on rising edge
//   btn_clear  in   clear button level (debounced), acts on rising edge
//   btn_lap    in   lap button level, acts on rising edge (LAP_EN builds only)
//   x          out  {sec_tens, sec_ones, hund_tens, hund_ones} packed BCD
//   running    out  high while the stopwatch is in RUN
//   overflow   out  one-cycle pulse on the wrap 59.99 -> 00.00
//
// Configuration
//   LAP_EN  when defined, adds btn_lap and a lap-hold display register.
//           When it is undefined, x always shows the live count.
//
// FSM states
//   state | meaning
//   IDLE  | cleared, count at zero, prescaler at zero
//   RUN   | prescaler counting, count advances on every tick
//   PAUSE | stopped, count and partial prescaler value are kept

module stopwatch_bcd_counter #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_clear,
`ifdef LAP_EN
  input  logic        btn_lap,
`endif
  output logic [15:0] x,
  output logic        running,
  output logic        overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   running_d;

  // Edge-detect history resets to 1 so a button held through reset release
  // does not register as a press.
  logic start_q, clear_q;
  logic start_e, clear_e;

  logic [PW-1:0] presc_q;
  logic [15:0]   count_q;
  logic [15:0]   count_inc;
  logic          tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b1;
      clear_q <= 1'b1;
    end else begin
      start_q <= btn_start;
      clear_q <= btn_clear;
    end
  end

  assign start_e = btn_start & ~start_q;
  assign clear_e = btn_clear & ~clear_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= running_d;
    end
  end

  // Next-state logic; clear has priority over a coincident start
  always_comb begin
    state_d = state_q;
    if (clear_e) begin
      state_d = IDLE;
    end else if (start_e) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: running is registered from the next state so it tracks
  // state_q exactly without decoding the state after the flop.
  always_comb begin
    running_d = (state_d == RUN);
  end

  assign tick = (state_q == RUN) && (presc_q == PRE_LAST);

  // BCD increment with ripple carry; sec_tens rolls over at 5 so 59.99 wraps
  // to 00.00.
  always_comb begin
    count_inc = count_q;
    if (count_q[3:0] != 4'd9) begin
      count_inc[3:0] = count_q[3:0] + 4'd1;
    end else begin
      count_inc[3:0] = 4'd0;
      if (count_q[7:4] != 4'd9) begin
        count_inc[7:4] = count_q[7:4] + 4'd1;
      end else begin
        count_inc[7:4] = 4'd0;
        if (count_q[11:8] != 4'd9) begin
          count_inc[11:8] = count_q[11:8] + 4'd1;
        end else begin
          count_inc[11:8] = 4'd0;
          if (count_q[15:12] != 4'd5) begin
            count_inc[15:12] = count_q[15:12] + 4'd1;
          end else begin
            count_inc[15:12] = 4'd0;
          end
        end
      end
    end
  end

  // Prescaler and live count. The prescaler only moves in RUN, so a pause
  // keeps the partial tick and resume continues from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      count_q  <= 16'h0000;
      overflow <= 1'b0;
    end else if (clear_e) begin
      presc_q  <= '0;
      count_q  <= 16'h0000;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (state_q == RUN) begin
        if (tick) begin
          presc_q  <= '0;
          count_q  <= count_inc;
          overflow <= (count_q == 16'h5999);
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

`ifdef LAP_EN
  logic        lap_q;
  logic        lap_e;
  logic        lap_hold;
  logic [15:0] lap_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q <= 1'b1;
    end else begin
      lap_q <= btn_lap;
    end
  end

  assign lap_e = btn_lap & ~lap_q;

  // A lap press toggles the hold only while running. Stopping the stopwatch
  // leaves an active hold in place until the next lap press in RUN, or a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_hold <= 1'b0;
      lap_val  <= 16'h0000;
    end else if (clear_e) begin
      lap_hold <= 1'b0;
      lap_val  <= 16'h0000;
    end else if (lap_e && (state_q == RUN)) begin
      if (!lap_hold) begin
        lap_hold <= 1'b1;
        lap_val  <= count_q;
      end else begin
        lap_hold <= 1'b0;
      end
    end
  end

  assign x = lap_hold ? lap_val : count_q;
`else
  assign x = count_q;
`endif

endmodule
